// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, controller state codes and the datapath mux selects.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RWB     = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_ADDI_EX = 4'd10,
      S_ADDI_WB = 4'd11,
      S_TRAP    = 4'd12
   } state_e;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle; the controller is the slave side.
interface multicycle_controller_if;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        pc_write;
   logic        pc_write_cond;
   logic        iord;
   logic        mem_read;
   logic        mem_write;
   logic        ir_write;
   logic        mem_to_reg;
   logic        reg_write;
   logic        reg_dst;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic [1:0]  pc_source;
   logic        trap;
   logic [3:0]  state;
   logic [31:0] inst_count;

   modport master (
      output opcode, zero, mem_ready,
      input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
             pc_source, trap, state, inst_count
   );

   modport slave (
      input  opcode, zero, mem_ready,
      output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
             pc_source, trap, state, inst_count
   );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational state -> datapath control map; zero latency, mem_ready only gates fetch writes.
module mc_output_decode
   import mips_pkg::*;
(
   input  state_e state_i,
   input  logic   mem_ready_i,
   input  logic   rst_ni,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.pc_source = PCSRC_ALU;
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
         end
         S_DECODE: ctrl_o.alu_src_b = SRCB_IMM_SH2;
         S_MEMADR, S_ADDI_EX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.iord      = 1'b1;
         end
         S_EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_REG;
            ctrl_o.alu_op    = ALU_FUNCT;
         end
         S_RWB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_src_b     = SRCB_REG;
            ctrl_o.alu_op        = ALU_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = PCSRC_JUMP;
         end
         S_ADDI_WB: ctrl_o.reg_write = 1'b1;
         default: ctrl_o = '0;
      endcase
      // Reset holds state at FETCH, so only the write strobes need suppressing here.
      if (!rst_ni) begin
         ctrl_o.pc_write      = 1'b0;
         ctrl_o.pc_write_cond = 1'b0;
         ctrl_o.ir_write      = 1'b0;
         ctrl_o.mem_write     = 1'b0;
         ctrl_o.reg_write     = 1'b0;
      end
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer with shared memory port; controls valid same cycle as state.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready, counts retired instructions, traps on bad opcodes.
module multicycle_controller
   import mips_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_,
   multicycle_controller_if.slave   bus
);

   state_e      state_q, state_d;
   logic        trap_q;
   logic [31:0] inst_count_q;
   ctrl_t       ctrl;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE:     state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDI_EX;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR:  state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
         S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
         S_EXEC:    state_d = S_RWB;
         S_ADDI_EX: state_d = S_ADDI_WB;
         S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
         S_TRAP:    state_d = S_TRAP;
         default:   state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q      <= S_FETCH;
         trap_q       <= 1'b0;
         inst_count_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == S_TRAP) trap_q <= 1'b1;
         // Every return to FETCH retires exactly one instruction.
         if (state_d == S_FETCH && state_q != S_FETCH) inst_count_q <= inst_count_q + 32'd1;
      end
   end

   mc_output_decode u_decode (
      .state_i     (state_q),
      .mem_ready_i (bus.mem_ready),
      .rst_ni      (rst_),
      .ctrl_o      (ctrl)
   );

   assign bus.pc_write      = ctrl.pc_write;
   assign bus.pc_write_cond = ctrl.pc_write_cond;
   assign bus.iord          = ctrl.iord;
   assign bus.mem_read      = ctrl.mem_read;
   assign bus.mem_write     = ctrl.mem_write;
   assign bus.ir_write      = ctrl.ir_write;
   assign bus.mem_to_reg    = ctrl.mem_to_reg;
   assign bus.reg_write     = ctrl.reg_write;
   assign bus.reg_dst       = ctrl.reg_dst;
   assign bus.alu_src_a     = ctrl.alu_src_a;
   assign bus.alu_src_b     = ctrl.alu_src_b;
   assign bus.alu_op        = ctrl.alu_op;
   assign bus.pc_source     = ctrl.pc_source;
   assign bus.trap          = trap_q;
   assign bus.state         = state_q;
   assign bus.inst_count    = inst_count_q;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencing FSM that replaces the single-cycle control unit when the MIPS datapath is refactored to share one memory port for instructions and data, with a single ALU reused across cycles. It decodes the opcode latched in the instruction register, drives every datapath mux select and write enable cycle by cycle, and stalls on a memory ready handshake. It also keeps a retired-instruction counter.

## Interface
- No parameters.
- clk  in  1  system clock, all state updates on rising edge
- rst_  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26] from the instruction register
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current access this cycle
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a  out  1 each  datapath controls
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- trap  out  1  illegal opcode seen; sticky until reset
- state  out  4  current state code (debug)
- inst_count  out  32  retired instructions

## Operation
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, TRAP 12. Codes 13–15 are unused and go to FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - If mem_ready=1, go to DECODE; otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 0x00 goes to EXEC.
  - 0x23 or 0x2B goes to MEMADR.
  - 0x04 goes to BRANCH.
  - 0x02 goes to JUMP.
  - 0x08 goes to ADDI_EX.
  - Any other opcode goes to TRAP.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD if opcode=0x23, else MEMWR.
- MEMRD: mem_read=1, iord=1. Go to MEMWB on mem_ready, else hold.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
- MEMWR: mem_write=1, iord=1. Go to FETCH on mem_ready, else hold. mem_write stays high while holding.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Go to FETCH.
- JUMP: pc_write=1, pc_source=10. Go to FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- TRAP: all write enables 0, trap=1. Stays in TRAP until reset.
- Any control not listed for a state is 0.
- inst_count increments by 1 on each transition into FETCH from any non-FETCH state. It wraps 0xFFFFFFFF to 0 without a flag.

## Timing
- Reset (rst_=0, asynchronous):
  - state=FETCH, inst_count=0, trap=0.
  - All write enables (pc_write, pc_write_cond, ir_write, mem_write, reg_write) are forced 0 combinationally while rst_=0.
  - The other outputs take their FETCH values.
- Control outputs are a combinational function of state, plus mem_ready for ir_write and pc_write. They are valid within the same cycle.
- Cycles per instruction with mem_ready held at 1:
  - beq and j: 3
  - R-type, sw and addi: 4
  - lw: 5
- Each low cycle of mem_ready in FETCH, MEMRD or MEMWR adds one cycle. Outputs are held stable during the stall.
- Reset asserted mid-instruction aborts the instruction. No further write enables are issued, and inst_count is not incremented.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

## Structure
- mips_pkg holds:
  - the opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - the 4-bit state encoding;
  - the ALUOp, ALUSrcB and PCSource encodings, shared with the ALU control and the datapath muxes.
- One sub-module is natural: mc_output_decode, a purely combinational map from state and mem_ready to the control outputs.
- The next-state register and inst_count stay in the top module.

## Test plan
- Reset with mem_ready=1, then release:
  - During reset: state=0, all writes 0.
  - First edge after release: ir_write=1 and pc_write=1, then state=1.
- lw (opcode 0x23) with mem_ready=1: states visited are 0,1,2,3,4,0 over 5 cycles. reg_write=1 and mem_to_reg=1 only in state 4. inst_count increments 0→1.
- sw (opcode 0x2B) with mem_ready low for 3 cycles in MEMWR: mem_write=1 for 4 consecutive cycles, then state returns to 0. Total 7 cycles.
- beq (opcode 0x04), zero=1 then zero=0: in state 8, pc_write_cond=1, alu_op=01 and pc_source=01 in both cases. Exactly 3 cycles each.
- Opcode 0x3F: state goes to 12 after DECODE and trap=1. It stays there for 10 or more cycles with all writes 0 and inst_count frozen. Reset clears trap.
- Preload inst_count near wrap: after 0xFFFFFFFF retirements plus one, inst_count=0. Use a forced value of 0xFFFFFFFF and run one j instruction (opcode 0x02).
